// File: rtl/io_bus_master.sv
// I/O bus master: single-beat read/write sequencer plus
// boundary-synchronised interrupt take/acknowledge logic.
module io_bus_master #(
    parameter int unsigned RD_WAIT  = 1,
    parameter logic [31:0] ISR_ADDR = 32'h0000_03FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        io_cs,
    output logic        io_wr,
    output logic        io_rd,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        intr,
    output logic        inta,
    input  logic        setie,
    input  logic        clrie,
    input  logic        boundary,
    output logic        ie,
    output logic        int_take,
    output logic [31:0] isr_addr
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} bus_state_t;
    typedef enum logic {INT_IDLE, INT_ACK} int_state_t;

    localparam logic [3:0] RD_WAIT_L = 4'(RD_WAIT);

    bus_state_t bus_state, bus_nxt;
    int_state_t int_state, int_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic       load, capture;
    logic       intr_q, take, ie_nxt;

    assign isr_addr = ISR_ADDR;

    always_comb begin
        bus_nxt  = bus_state;
        wait_nxt = wait_cnt;
        load     = 1'b0;
        capture  = 1'b0;
        io_cs    = 1'b0;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        done     = 1'b0;
        busy     = (bus_state != IDLE);
        unique case (bus_state)
            IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (we) begin
                        bus_nxt = WRITE;
                    end else begin
                        bus_nxt  = READ;
                        wait_nxt = RD_WAIT_L;
                    end
                end
            end
            WRITE: begin
                io_cs   = 1'b1;
                io_wr   = 1'b1;
                bus_nxt = DONE;
            end
            READ: begin
                io_cs = 1'b1;
                io_rd = 1'b1;
                // counter reaching zero marks the last strobe cycle
                if (wait_cnt == 4'd0) begin
                    capture = 1'b1;
                    bus_nxt = DONE;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                bus_nxt = IDLE;
            end
            default: bus_nxt = IDLE;
        endcase
    end

    // a pending access this cycle defers the interrupt
    assign take = (int_state == INT_IDLE) & ie & intr_q & boundary
                & (bus_state == IDLE) & ~req;

    always_comb begin
        int_nxt = int_state;
        inta    = (int_state == INT_ACK);
        unique case (int_state)
            INT_IDLE: if (take) int_nxt = INT_ACK;
            INT_ACK:  if (!intr_q) int_nxt = INT_IDLE;
            default:  int_nxt = INT_IDLE;
        endcase
        if (clrie || take) ie_nxt = 1'b0;
        else if (setie)    ie_nxt = 1'b1;
        else               ie_nxt = ie;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_state <= IDLE;
            int_state <= INT_IDLE;
            wait_cnt  <= 4'd0;
            io_addr   <= 32'd0;
            io_wdata  <= 32'd0;
            rdata     <= 32'd0;
            intr_q    <= 1'b0;
            ie        <= 1'b0;
            int_take  <= 1'b0;
        end else begin
            bus_state <= bus_nxt;
            int_state <= int_nxt;
            wait_cnt  <= wait_nxt;
            intr_q    <= intr;
            ie        <= ie_nxt;
            int_take  <= take;
            if (load) begin
                io_addr  <= addr;
                io_wdata <= wdata;
            end
            if (capture) rdata <= io_rdata;
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: per-cycle vector table
// plus hand-written interrupt and reset sequences.
module tb_io_bus_master;

    typedef struct packed {
        logic        rst, req, we;
        logic [31:0] addr, wdata, iord;
        logic        intr, setie, clrie, bnd;
    } in_t;

    typedef struct packed {
        logic        cs, wr, rd, done, busy, ie, inta, take;
        logic [31:0] ioaddr, iowdata, rdata;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, req, we, intr, setie, clrie, boundary;
    logic [31:0] addr, wdata, io_rdata;
    logic [31:0] rdata, io_addr, io_wdata, isr_addr;
    logic        busy, done, io_cs, io_wr, io_rd, inta, ie, int_take;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    in_t  v;
    out_t got;

    io_bus_master #(.RD_WAIT(1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .io_cs(io_cs),
        .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata),
        .intr(intr), .inta(inta), .setie(setie),
        .clrie(clrie), .boundary(boundary), .ie(ie),
        .int_take(int_take), .isr_addr(isr_addr)
    );

    always #5 clk = ~clk;

    assign got = {io_cs, io_wr, io_rd, done, busy, ie, inta,
                  int_take, io_addr, io_wdata, rdata};

    function automatic in_t mi(
        logic r, logic q, logic w, logic [31:0] a,
        logic [31:0] d, logic [31:0] rd,
        logic it, logic s, logic c, logic b);
        in_t x;
        x = '{r, q, w, a, d, rd, it, s, c, b};
        return x;
    endfunction

    function automatic out_t mo(
        logic [7:0] f, logic [31:0] a,
        logic [31:0] d, logic [31:0] r);
        out_t x;
        x = {f, a, d, r};
        return x;
    endfunction

    task automatic cyc(input in_t x);
        reset    = x.rst;
        req      = x.req;
        we       = x.we;
        addr     = x.addr;
        wdata    = x.wdata;
        io_rdata = x.iord;
        intr     = x.intr;
        setie    = x.setie;
        clrie    = x.clrie;
        boundary = x.bnd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] g,
                       input logic [31:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    initial begin
        // flags: cs wr rd done busy ie inta take
        tbl.push_back('{mi(1,0,0,0,0,0,0,0,0,0),
            mo(8'b0000_0000, 0, 0, 0)});
        tbl.push_back('{mi(0,1,1,32'h10,32'hDEADBEEF,0,0,0,0,0),
            mo(8'b1100_1000, 32'h10, 32'hDEADBEEF, 0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,0),
            mo(8'b0001_1000, 32'h10, 32'hDEADBEEF, 0)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,0),
            mo(8'b0000_0000, 32'h10, 32'hDEADBEEF, 0)});
        tbl.push_back('{mi(0,1,0,32'h20,0,0,0,0,0,0),
            mo(8'b1010_1000, 32'h20, 0, 0)});
        tbl.push_back('{mi(0,0,0,0,0,32'hDEADBEEF,0,0,0,0),
            mo(8'b1010_1000, 32'h20, 0, 0)});
        tbl.push_back('{mi(0,0,0,0,0,32'hDEADBEEF,0,0,0,0),
            mo(8'b0001_1000, 32'h20, 0, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,0),
            mo(8'b0000_0000, 32'h20, 0, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,1,1,32'h30,32'h12345678,0,0,0,0,0),
            mo(8'b1100_1000, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,1,0,32'h40,0,0,0,0,0,0),
            mo(8'b0001_1000, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,0,0),
            mo(8'b0000_0000, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,1,0,0),
            mo(8'b0000_0100, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,1,1,0),
            mo(8'b0000_0000, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,1,0,0),
            mo(8'b0000_0100, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,0,0,1,0),
            mo(8'b0000_0000, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,1,0,0,1),
            mo(8'b0000_0000, 32'h30, 32'h12345678, 32'hDEADBEEF)});
        tbl.push_back('{mi(0,0,0,0,0,0,1,0,0,1),
            mo(8'b0000_0000, 32'h30, 32'h12345678, 32'hDEADBEEF)});

        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].i);
            tests++;
            if (got !== tbl[k].o) begin
                fails++;
                $display("FAIL vec%0d got=%h exp=%h",
                         k, got, tbl[k].o);
            end
        end
        chk("isr_addr", isr_addr, 32'h0000_03FC);

        // interrupt take and acknowledge, intr held high
        v = mi(0,0,0,0,0,0,1,1,0,0);
        cyc(v);
        chk("a1_ie", {31'd0, ie}, 1);
        v.setie = 0; v.bnd = 1;
        cyc(v);
        chk("a2_take", {31'd0, int_take}, 1);
        chk("a2_ie", {31'd0, ie}, 0);
        chk("a2_inta", {31'd0, inta}, 1);
        v.setie = 1;
        cyc(v);
        chk("a3_take", {31'd0, int_take}, 0);
        chk("a3_inta", {31'd0, inta}, 1);
        chk("a3_ie", {31'd0, ie}, 1);
        v.setie = 0; v.bnd = 0; v.intr = 0;
        cyc(v);
        chk("a4_inta", {31'd0, inta}, 1);
        cyc(v);
        chk("a5_inta", {31'd0, inta}, 0);
        chk("a5_take", {31'd0, int_take}, 0);

        // access coincident with a qualifying boundary
        v.intr = 1;
        cyc(v);
        chk("b1_take", {31'd0, int_take}, 0);
        v.req = 1; v.we = 1; v.addr = 32'h50;
        v.wdata = 32'h1; v.bnd = 1;
        cyc(v);
        chk("b2_wr", {31'd0, io_wr}, 1);
        chk("b2_take", {31'd0, int_take}, 0);
        chk("b2_inta", {31'd0, inta}, 0);
        v.req = 0; v.bnd = 0;
        cyc(v);
        chk("b3_done", {31'd0, done}, 1);
        cyc(v);
        chk("b4_busy", {31'd0, busy}, 0);
        chk("b4_inta", {31'd0, inta}, 0);
        v.bnd = 1;
        cyc(v);
        chk("b5_take", {31'd0, int_take}, 1);
        chk("b5_inta", {31'd0, inta}, 1);
        v.bnd = 0; v.intr = 0;
        cyc(v);
        cyc(v);
        chk("b7_inta", {31'd0, inta}, 0);

        // reset in the middle of a read
        v.req = 1; v.we = 0; v.addr = 32'h60;
        v.iord = 32'hAAAA5555;
        cyc(v);
        chk("c1_rd", {31'd0, io_rd}, 1);
        v.rst = 1; v.req = 0;
        cyc(v);
        chk("c2_strobes", {29'd0, io_cs, io_rd, io_wr}, 0);
        chk("c2_done", {31'd0, done}, 0);
        chk("c2_rdata", rdata, 0);
        chk("c2_ioaddr", io_addr, 0);
        v.rst = 0;
        cyc(v);
        chk("c3_done", {31'd0, done}, 0);
        chk("c3_busy", {31'd0, busy}, 0);
        chk("c3_rdata", rdata, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
